// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_seq_pkg
//  Description : Shared types and constants for the program-counter
//                sequencer: run/halt state encoding, default vectors, the
//                return-address-stack frame layout and redirect priority
//                codes with the helper that picks one.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    localparam int unsigned DEF_PC_W         = 16;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_INT_VECTOR   = 32'h0000_0010;

    // RAS frame at the default width; the tag marks frames pushed by
    // interrupt entry so that their RETURN also restores interrupt state.
    typedef struct packed {
        logic [DEF_PC_W-1:0] addr;
        logic                isr_tag;
    } ras_entry_t;

    // Redirect selection codes, highest priority first.
    localparam logic [2:0] SEL_INT    = 3'd0;
    localparam logic [2:0] SEL_HALT   = 3'd1;
    localparam logic [2:0] SEL_RET    = 3'd2;
    localparam logic [2:0] SEL_JUMP   = 3'd3;
    localparam logic [2:0] SEL_BRANCH = 3'd4;
    localparam logic [2:0] SEL_SEQ    = 3'd5;
    localparam logic [2:0] SEL_HOLD   = 3'd6;

    function automatic logic [2:0] pick_redirect(
        input logic irq,
        input logic halt,
        input logic ret,
        input logic jmp,
        input logic br
    );
        logic [2:0] sel;
        if (irq)       sel = SEL_INT;
        else if (halt) sel = SEL_HALT;
        else if (ret)  sel = SEL_RET;
        else if (jmp)  sel = SEL_JUMP;
        else if (br)   sel = SEL_BRANCH;
        else           sel = SEL_SEQ;
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_ras.sv
`default_nettype none
// ============================================================================
//  Module      : ras_stack
//  Description : Parametrised LIFO used as the return-address stack.
//                A push while full and a pop while empty are ignored; the
//                caller flags those conditions.
//  Ports       : clk, reset (sync, active-high), push, pop, din -> dout
//                (top of stack, combinational), count, full, empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module ras_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 17
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             do_push;
    logic             do_pop;
    logic [AW-1:0]    top_idx;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    // When empty this wraps to the last slot; the caller ignores dout then.
    assign top_idx = AW'(count_q - (AW+1)'(1));
    assign dout    = mem_q[top_idx];
    assign count   = count_q;

    always_comb begin
        count_d = count_q;
        if (do_push) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone defines which slots are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[count_q[AW-1:0]] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program counter sequencer. Produces the fetch address and
//                resolves interrupt, halt, return, jump/jump-and-link and
//                branch redirects with a return-address stack.
//  Ports       : clk, reset (sync, active-high), clk_en;
//                decode inputs halt_cmd, branch_taken/branch_imm,
//                jump_taken/jump_link/jump_imm, return_cmd,
//                int_enable_cmd, int_disable_cmd, int_trigger, int_req;
//                outputs pc, halted, int_active, int_enabled, ras_count,
//                ras_overflow, ras_underflow (all registered).
//  Config      : define PC_INT_NESTING_EN to allow nested interrupts.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_W         = DEF_PC_W,
    parameter int unsigned STACK_DEPTH  = 8,
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] INT_VECTOR   = DEF_INT_VECTOR
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clk_en,
    input  logic                          halt_cmd,
    input  logic                          branch_taken,
    input  logic [5:0]                    branch_imm,
    input  logic                          jump_taken,
    input  logic                          jump_link,
    input  logic [11:0]                   jump_imm,
    input  logic                          return_cmd,
    input  logic                          int_enable_cmd,
    input  logic                          int_disable_cmd,
    input  logic                          int_trigger,
    input  logic                          int_req,
    output logic [PC_W-1:0]               pc,
    output logic                          halted,
    output logic                          int_active,
    output logic                          int_enabled,
    output logic [$clog2(STACK_DEPTH):0]  ras_count,
    output logic                          ras_overflow,
    output logic                          ras_underflow
);

    localparam int unsigned     CNT_W      = $clog2(STACK_DEPTH) + 1;
    localparam logic [PC_W-1:0] C_RESET_PC = PC_W'(RESET_VECTOR);
    localparam logic [PC_W-1:0] C_INT_PC   = PC_W'(INT_VECTOR);

    typedef struct packed {
        logic [PC_W-1:0] addr;
        logic            isr_tag;
    } frame_t;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            int_active_q, int_active_d;
    logic            int_enabled_q, int_enabled_d;
    logic            ras_overflow_q, ras_overflow_d;
    logic            ras_underflow_q, ras_underflow_d;

    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] branch_tgt;
    logic [PC_W-1:0] jump_tgt;
    logic            int_go;
    logic            enable_ok;
    logic [2:0]      sel;
    logic            ras_push;
    logic            ras_pop;
    frame_t          push_frame;
    frame_t          top_frame;
    logic [CNT_W-1:0] ras_cnt;
    logic            ras_full;
    logic            ras_empty;

    // Offsets are word offsets: append a zero, then sign-extend to PC_W.
    assign seq_pc     = pc_q + PC_W'(2);
    assign branch_tgt = seq_pc + PC_W'($signed({branch_imm, 1'b0}));
    assign jump_tgt   = seq_pc + PC_W'($signed({jump_imm, 1'b0}));

`ifdef PC_INT_NESTING_EN
    logic [CNT_W-1:0] nest_q, nest_d;
    assign enable_ok = 1'b1;
`else
    // Without nesting, an ISR cannot re-enable interrupts for itself.
    assign enable_ok = ~int_active_q;
`endif

    ras_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PC_W + 1)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (push_frame),
        .dout  (top_frame),
        .count (ras_cnt),
        .full  (ras_full),
        .empty (ras_empty)
    );

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        int_active_d    = int_active_q;
        int_enabled_d   = int_enabled_q;
        ras_overflow_d  = ras_overflow_q;
        ras_underflow_d = ras_underflow_q;
        ras_push        = 1'b0;
        ras_pop         = 1'b0;
        push_frame      = '{addr: seq_pc, isr_tag: 1'b0};
        int_go          = 1'b0;
        sel             = SEL_HOLD;
`ifdef PC_INT_NESTING_EN
        nest_d          = nest_q;
`endif
        if (clk_en) begin
            // A halted core only wakes on the external level request.
            if (state_q == ST_HALTED) begin
                int_go = int_enabled_q & int_req;
                sel    = int_go ? SEL_INT : SEL_HOLD;
            end else begin
                int_go = int_enabled_q & (int_req | int_trigger);
                sel    = pick_redirect(int_go, halt_cmd, return_cmd,
                                       jump_taken, branch_taken);
            end

            case (sel)
                SEL_INT: begin
                    ras_push           = 1'b1;
                    push_frame.isr_tag = 1'b1;
                    pc_d               = C_INT_PC;
                    int_active_d       = 1'b1;
                    state_d            = ST_RUN;
`ifdef PC_INT_NESTING_EN
                    if (!ras_full) begin
                        nest_d = nest_q + CNT_W'(1);
                    end
`endif
                end
                SEL_HALT: begin
                    state_d = ST_HALTED;
                end
                SEL_RET: begin
                    ras_pop = 1'b1;
                    if (ras_empty) begin
                        pc_d            = seq_pc;
                        ras_underflow_d = 1'b1;
                    end else begin
                        pc_d = top_frame.addr;
                        if (top_frame.isr_tag) begin
                            int_enabled_d = 1'b1;
`ifdef PC_INT_NESTING_EN
                            if (nest_q <= CNT_W'(1)) begin
                                int_active_d = 1'b0;
                            end
                            if (nest_q != '0) begin
                                nest_d = nest_q - CNT_W'(1);
                            end
`else
                            int_active_d = 1'b0;
`endif
                        end
                    end
                end
                SEL_JUMP: begin
                    pc_d     = jump_tgt;
                    ras_push = jump_link;
                end
                SEL_BRANCH: begin
                    pc_d = branch_tgt;
                end
                SEL_SEQ: begin
                    pc_d = seq_pc;
                end
                default: begin
                end
            endcase

            if (state_q == ST_RUN) begin
                if (int_enable_cmd && enable_ok) begin
                    int_enabled_d = 1'b1;
                end
                if (int_disable_cmd) begin
                    int_enabled_d = 1'b0;
                end
            end
            // Interrupt entry always leaves interrupts masked.
            if (sel == SEL_INT) begin
                int_enabled_d = 1'b0;
            end

            if (ras_push && ras_full) begin
                ras_overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_RUN;
            pc_q            <= C_RESET_PC;
            int_active_q    <= 1'b0;
            int_enabled_q   <= 1'b0;
            ras_overflow_q  <= 1'b0;
            ras_underflow_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            int_active_q    <= int_active_d;
            int_enabled_q   <= int_enabled_d;
            ras_overflow_q  <= ras_overflow_d;
            ras_underflow_q <= ras_underflow_d;
        end
    end

`ifdef PC_INT_NESTING_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            nest_q <= '0;
        end else begin
            nest_q <= nest_d;
        end
    end
`endif

    assign pc            = pc_q;
    assign halted        = (state_q == ST_HALTED);
    assign int_active    = int_active_q;
    assign int_enabled   = int_enabled_q;
    assign ras_count     = ras_cnt;
    assign ras_overflow  = ras_overflow_q;
    assign ras_underflow = ras_underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Self-checking bench for pc_sequencer (default build,
//                PC_W=16, STACK_DEPTH=8). Vectors of {commands, expected
//                outputs} are applied one per clock; expectations are queued
//                when driven and popped when the registered outputs appear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    // Command bit layout: halt br jt jl ret ien idis trig req
    localparam logic [8:0] C_NOP  = 9'h000;
    localparam logic [8:0] C_HALT = 9'h100;
    localparam logic [8:0] C_BR   = 9'h080;
    localparam logic [8:0] C_JT   = 9'h040;
    localparam logic [8:0] C_JL   = 9'h060;
    localparam logic [8:0] C_RET  = 9'h010;
    localparam logic [8:0] C_IEN  = 9'h008;
    localparam logic [8:0] C_IDIS = 9'h004;
    localparam logic [8:0] C_TRIG = 9'h002;
    localparam logic [8:0] C_REQ  = 9'h001;

    logic        clk = 1'b0;
    logic        reset, clk_en, halt_cmd, branch_taken, jump_taken, jump_link;
    logic [5:0]  branch_imm;
    logic [11:0] jump_imm;
    logic        return_cmd, int_enable_cmd, int_disable_cmd, int_trigger, int_req;
    logic [15:0] pc;
    logic        halted, int_active, int_enabled, ras_overflow, ras_underflow;
    logic [3:0]  ras_count;

    pc_sequencer #(
        .PC_W         (16),
        .STACK_DEPTH  (8),
        .RESET_VECTOR (32'h0000_0000),
        .INT_VECTOR   (32'h0000_0010)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .clk_en          (clk_en),
        .halt_cmd        (halt_cmd),
        .branch_taken    (branch_taken),
        .branch_imm      (branch_imm),
        .jump_taken      (jump_taken),
        .jump_link       (jump_link),
        .jump_imm        (jump_imm),
        .return_cmd      (return_cmd),
        .int_enable_cmd  (int_enable_cmd),
        .int_disable_cmd (int_disable_cmd),
        .int_trigger     (int_trigger),
        .int_req         (int_req),
        .pc              (pc),
        .halted          (halted),
        .int_active      (int_active),
        .int_enabled     (int_enabled),
        .ras_count       (ras_count),
        .ras_overflow    (ras_overflow),
        .ras_underflow   (ras_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic        hlt, ia, ie;
        logic [3:0]  cnt;
        logic        ovf, unf;
    } exp_t;

    typedef struct {
        logic        en;
        logic [8:0]  cmd;
        logic [11:0] imm;
        exp_t        exp;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk_exp(input logic [15:0] p, input logic h, input logic a,
                                    input logic e, input logic [3:0] c,
                                    input logic o, input logic u);
        exp_t x;
        x.pc = p; x.hlt = h; x.ia = a; x.ie = e; x.cnt = c; x.ovf = o; x.unf = u;
        return x;
    endfunction

    function automatic vec_t mk(input logic en, input logic [8:0] cmd, input logic [11:0] imm,
                                input logic [15:0] p, input logic h, input logic a,
                                input logic e, input logic [3:0] c,
                                input logic o, input logic u);
        vec_t v;
        v.en = en; v.cmd = cmd; v.imm = imm;
        v.exp = mk_exp(p, h, a, e, c, o, u);
        return v;
    endfunction

    task automatic drive(input logic en, input logic [8:0] cmd, input logic [11:0] imm);
        clk_en          = en;
        halt_cmd        = cmd[8];
        branch_taken    = cmd[7];
        jump_taken      = cmd[6];
        jump_link       = cmd[5];
        return_cmd      = cmd[4];
        int_enable_cmd  = cmd[3];
        int_disable_cmd = cmd[2];
        int_trigger     = cmd[1];
        int_req         = cmd[0];
        branch_imm      = imm[5:0];
        jump_imm        = imm;
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic compare_outputs(input int idx);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard step %0d: got empty queue, expected an entry", idx);
        end else begin
            e = sb.pop_front();
            chk("pc",            idx, 32'(pc),            32'(e.pc));
            chk("halted",        idx, 32'(halted),        32'(e.hlt));
            chk("int_active",    idx, 32'(int_active),    32'(e.ia));
            chk("int_enabled",   idx, 32'(int_enabled),   32'(e.ie));
            chk("ras_count",     idx, 32'(ras_count),     32'(e.cnt));
            chk("ras_overflow",  idx, 32'(ras_overflow),  32'(e.ovf));
            chk("ras_underflow", idx, 32'(ras_underflow), 32'(e.unf));
        end
    endtask

    initial begin
        // ---- vector table ----
        vecs.push_back(mk(1, C_NOP, 12'h000, 16'h0002, 0,0,0,0,0,0));
        vecs.push_back(mk(1, C_NOP, 12'h000, 16'h0004, 0,0,0,0,0,0));
        vecs.push_back(mk(1, C_NOP, 12'h000, 16'h0006, 0,0,0,0,0,0));
        vecs.push_back(mk(1, C_NOP, 12'h000, 16'h0008, 0,0,0,0,0,0));
        vecs.push_back(mk(0, C_NOP, 12'h000, 16'h0008, 0,0,0,0,0,0));
        vecs.push_back(mk(0, C_JT,  12'h00B, 16'h0008, 0,0,0,0,0,0));
        vecs.push_back(mk(1, C_JT,  12'h00B, 16'h0020, 0,0,0,0,0,0));
        vecs.push_back(mk(1, C_BR,  12'h03E, 16'h001E, 0,0,0,0,0,0));
        vecs.push_back(mk(1, C_JT,  12'hFEF, 16'hFFFE, 0,0,0,0,0,0));
        vecs.push_back(mk(1, C_NOP, 12'h000, 16'h0000, 0,0,0,0,0,0));
        vecs.push_back(mk(1, C_JT,  12'h01F, 16'h0040, 0,0,0,0,0,0));
        vecs.push_back(mk(1, C_JL,  12'h010, 16'h0062, 0,0,0,1,0,0));
        vecs.push_back(mk(1, C_RET, 12'h000, 16'h0042, 0,0,0,0,0,0));
        vecs.push_back(mk(1, C_RET, 12'h000, 16'h0044, 0,0,0,0,0,1));
        vecs.push_back(mk(1, C_IEN, 12'h000, 16'h0046, 0,0,1,0,0,1));
        vecs.push_back(mk(1, C_JT,  12'h05C, 16'h0100, 0,0,1,0,0,1));
        vecs.push_back(mk(1, C_REQ, 12'h000, 16'h0010, 0,1,0,1,0,1));
        vecs.push_back(mk(1, C_IEN, 12'h000, 16'h0012, 0,1,0,1,0,1));
        vecs.push_back(mk(1, C_RET, 12'h000, 16'h0102, 0,0,1,0,0,1));
        vecs.push_back(mk(1, C_TRIG | C_HALT | C_JT, 12'h005, 16'h0010, 0,1,0,1,0,1));
        vecs.push_back(mk(1, C_RET, 12'h000, 16'h0104, 0,0,1,0,0,1));
        vecs.push_back(mk(1, C_IEN | C_IDIS, 12'h000, 16'h0106, 0,0,0,0,0,1));
        vecs.push_back(mk(1, C_IEN, 12'h000, 16'h0108, 0,0,1,0,0,1));
        vecs.push_back(mk(1, C_JT,  12'hF93, 16'h0030, 0,0,1,0,0,1));
        vecs.push_back(mk(1, C_HALT, 12'h000, 16'h0030, 1,0,1,0,0,1));
        for (int i = 0; i < 10; i++) begin
            vecs.push_back(mk(1, (i == 3) ? C_TRIG : ((i == 5) ? C_JT : C_NOP),
                              12'h004, 16'h0030, 1,0,1,0,0,1));
        end
        vecs.push_back(mk(1, C_REQ, 12'h000, 16'h0010, 0,1,0,1,0,1));
        vecs.push_back(mk(1, C_RET, 12'h000, 16'h0032, 0,0,1,0,0,1));
        vecs.push_back(mk(1, C_HALT | C_RET, 12'h000, 16'h0032, 1,0,1,0,0,1));
        vecs.push_back(mk(1, C_REQ, 12'h000, 16'h0010, 0,1,0,1,0,1));
        vecs.push_back(mk(1, C_RET, 12'h000, 16'h0034, 0,0,1,0,0,1));
        vecs.push_back(mk(1, C_JT | C_BR, 12'h020, 16'h0076, 0,0,1,0,0,1));
        vecs.push_back(mk(1, C_RET | C_JL, 12'h000, 16'h0078, 0,0,1,0,0,1));
        vecs.push_back(mk(1, C_IDIS, 12'h000, 16'h007A, 0,0,0,0,0,1));
        vecs.push_back(mk(1, C_REQ, 12'h000, 16'h007C, 0,0,0,0,0,1));
        for (int i = 0; i < 9; i++) begin
            vecs.push_back(mk(1, C_JL, 12'h000, 16'h007E + 16'(2 * i), 0,0,0,
                              (i < 8) ? 4'(i + 1) : 4'd8, (i == 8), 1));
        end
        vecs.push_back(mk(1, C_RET, 12'h000, 16'h008C, 0,0,0,7,1,1));
        vecs.push_back(mk(1, C_RET, 12'h000, 16'h008A, 0,0,0,6,1,1));
        vecs.push_back(mk(1, C_JL,  12'h000, 16'h008C, 0,0,0,7,1,1));

        // ---- reset state ----
        reset = 1'b1;
        drive(1'b1, C_NOP, 12'h000);
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(mk_exp(16'h0000, 0,0,0,0,0,0));
        compare_outputs(-1);
        reset = 1'b0;

        // ---- table-driven run ----
        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].cmd, vecs[i].imm);
            sb.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            compare_outputs(i);
        end

        // ---- reset mid-sequence overrides clk_en and pending commands ----
        reset = 1'b1;
        drive(1'b0, C_JL | C_REQ, 12'h010);
        sb.push_back(mk_exp(16'h0000, 0,0,0,0,0,0));
        @(posedge clk);
        #1;
        compare_outputs(1000);
        reset = 1'b0;
        drive(1'b1, C_NOP, 12'h000);
        sb.push_back(mk_exp(16'h0002, 0,0,0,0,0,0));
        @(posedge clk);
        #1;
        compare_outputs(1001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised successor to the 16-bit program counter. Generates the fetch address and resolves branch, jump, jump-and-link, return, halt and interrupt redirects. Holds an internal return-address stack (RAS) for JL/RETURN and interrupt entry/exit. Sits between instruction decode / branch comparator and instruction memory.

Parameters:
PC_W, 16, program counter width in bits; all address arithmetic is modulo 2^PC_W.
STACK_DEPTH, 8, number of RAS entries (power of 2, >=2).
RESET_VECTOR, 0, PC value after reset.
INT_VECTOR, 16'h0010, PC loaded on interrupt entry (truncated to PC_W).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
clk_en  in  1  advance enable; when low, all state holds
halt_cmd  in  1  HALT decoded
branch_taken  in  1  from branch comparator
branch_imm  in  6  signed word offset
jump_taken  in  1  J or JL decoded
jump_link  in  1  with jump_taken: JL, push return address
jump_imm  in  12  signed word offset
return_cmd  in  1  RETURN decoded, pop RAS
int_enable_cmd  in  1  INT_ENABLE
int_disable_cmd  in  1  INT_DISABLE
int_trigger  in  1  INT_TRIGGER (software interrupt)
int_req  in  1  external interrupt request, level
pc  out  PC_W  current fetch address
halted  out  1  core halted
int_active  out  1  inside an interrupt service routine
int_enabled  out  1  global interrupt enable
ras_count  out  $clog2(STACK_DEPTH)+1  current RAS occupancy
ras_overflow  out  1  sticky, push while full
ras_underflow  out  1  sticky, pop while empty

Behaviour:
- Reset is synchronous and active-high on clk: pc=RESET_VECTOR, state=RUN, halted=0, int_active=0, int_enabled=0, ras_count=0, both sticky flags=0. Reset overrides clk_en.
- All updates occur on the rising edge when clk_en=1. Outputs are registered, with one-cycle latency from command to new pc.
- seq = pc+2. Branch target = seq + (sext(branch_imm)<<1). Jump target = seq + (sext(jump_imm)<<1). Results wrap modulo 2^PC_W.
- States:
  - RUN: normal operation.
  - HALTED: pc frozen, halted=1.
- Priority in RUN, highest first:
  1. Interrupt: int_enabled & (int_req|int_trigger). Push {seq, isr_tag=1}. pc=INT_VECTOR. int_enabled=0. int_active=1. The current instruction is abandoned.
  2. halt_cmd: go to HALTED, pc unchanged.
  3. return_cmd: pop. pc=popped address. If popped isr_tag=1: int_active=0, int_enabled=1.
  4. jump_taken: pc=jump target. If jump_link, push {seq, tag=0}.
  5. branch_taken: pc=branch target.
  6. Otherwise pc=seq.
- int_enable_cmd / int_disable_cmd set or clear int_enabled in the same cycle. If both are asserted, disable wins. An interrupt entry in the same cycle overrides both (int_enabled=0).
- HALTED: exits only via reset, or via int_req while int_enabled. The exit performs interrupt entry and pushes pc+2 of the halt instruction. int_trigger is ignored while HALTED.
- RAS full + push: entry is dropped, ras_overflow=1, pc redirect still occurs.
- RAS empty + pop: pc=seq, ras_underflow=1, interrupt state unchanged.
- Sticky flags clear only on reset.
- Simultaneous push and pop cannot occur (priority makes them exclusive).

Optional Feature:
PC_INT_NESTING_EN
- Defined: int_enable_cmd is honoured while int_active=1, so a nested interrupt can push a second tagged frame. int_active stays 1 until the last tagged frame is popped; track this with a nesting counter of width $clog2(STACK_DEPTH)+1.
- Undefined: int_enable_cmd is ignored while int_active=1. No nesting; int_active is a single flag.

Decomposition:
- Package pc_seq_pkg: state enum (RUN, HALTED), default RESET_VECTOR/INT_VECTOR constants, RAS entry struct {addr, isr_tag}, priority encoding localparams.
- Sub-module ras_stack: parametrised LIFO of STACK_DEPTH x (PC_W+1). Ports push, pop, din, dout, count, full, empty. Synchronous reset.

Test Plan:
- Reset, then 4 cycles with clk_en=1 and no commands -> pc 0,2,4,6,8. Hold clk_en=0 for 2 cycles -> pc stays 8.
- pc=0x0020 with branch_taken, branch_imm=6'b111110 (-2) -> pc=0x001E. pc=0xFFFE with no command -> pc=0x0000 (wrap).
- pc=0x0040, JL jump_imm=0x010 -> pc=0x0062, ras_count=1. Then RETURN -> pc=0x0042, ras_count=0. A second RETURN -> pc=0x0044, ras_underflow=1.
- int_enable_cmd, then int_req=1 at pc=0x0100 -> pc=0x0010, int_active=1, int_enabled=0. RETURN -> pc=0x0102, int_active=0, int_enabled=1.
- HALT at pc=0x0030 -> halted=1, pc holds for 10 cycles. int_req with int_enabled=1 -> pc=0x0010, halted=0. RETURN -> pc=0x0032.
- 9 consecutive JL with STACK_DEPTH=8 -> ras_count=8, ras_overflow=1. Reset mid-sequence -> all outputs return to reset values.
